mem_wb_stage: RTL

Memory-access stage of the 5-stage RV32I core, sitting between the EXE/MEM pipeline register and the register-file writeback. It issues load/store requests to data memory with a ready handshake and stalls the pipeline on wait states. It aligns store data, extracts and sign/zero-extends load data, and selects the writeback value. The result is registered into the MEM/WB pipeline register.

---
 rtl/mem_wb_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB register; handshake FSM stalls on wait states.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_wb_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_pc_to_reg,
  input  logic [31:0]       mem_alu_out,
  input  logic [31:0]       mem_rs2_data,
  input  logic [4:0]        mem_rd_addr,
  input  logic              mem_rdsrc,
  input  logic              mem_memread,
  input  logic [3:0]        mem_memwrite,
  input  logic              mem_memtoreg,
  input  logic              mem_regwrite,
  input  logic [2:0]        mem_ld_type,
  output logic              dm_req,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ready,
  output logic              stall,
  output logic              misalign_err,
  output logic [4:0]        wb_rd_addr,
  output logic [31:0]       wb_rd_data,
  output logic              wb_regwrite
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        access;
  logic        mis;
  logic [4:0]  lane_sh;
  logic [31:0] sh;
  logic [31:0] load_data;
  logic [31:0] wb_sel;

  assign access  = mem_memread | (mem_memwrite != 4'hf);
  assign lane_sh = {mem_alu_out[1:0], 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
  // Size comes from funct3, which also encodes SB/SH/SW for stores.
  always_comb begin
    mis = 1'b0;
    if (access && state == IDLE) begin
      case (mem_ld_type[1:0])
        2'b01:   mis = mem_alu_out[0];
        2'b10:   mis = (mem_alu_out[1:0] != 2'b00);
        default: mis = 1'b0;
      endcase
    end
  end
`else
  assign mis = 1'b0;
`endif

  assign misalign_err = mis;

  // Handshake state register; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and request/stall generation.
  always_comb begin
    state_nxt = state;
    dm_req    = 1'b0;
    unique case (state)
      IDLE: begin
        dm_req = access & ~mis;
        if (access && !mis && !dm_ready)
          state_nxt = WAIT;
      end
      WAIT: begin
        dm_req = 1'b1;
        if (dm_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall    = dm_req & ~dm_ready;
  assign dm_we    = dm_req ? mem_memwrite : 4'hf;
  assign dm_addr  = mem_alu_out[ADDR_W-1:0];
  assign dm_wdata = mem_rs2_data << lane_sh;
  assign sh       = dm_rdata >> lane_sh;

  // Load lane extraction and sign/zero extension.
  always_comb begin
    load_data = dm_rdata;
    case (mem_ld_type)
      3'b000:  load_data = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_data = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_data = {24'h0, sh[7:0]};
      3'b101:  load_data = {16'h0, sh[15:0]};
      default: load_data = dm_rdata;
    endcase
  end

  // Writeback source select; PC value wins over load data.
  always_comb begin
    wb_sel = mem_alu_out;
    if (mem_rdsrc)         wb_sel = mem_pc_to_reg;
    else if (mem_memtoreg) wb_sel = load_data;
  end

  // MEM/WB register; stalls and trapped accesses insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_addr  <= 5'd0;
      wb_rd_data  <= 32'd0;
      wb_regwrite <= 1'b0;
    end else if (stall || mis) begin
      wb_rd_addr  <= 5'd0;
      wb_rd_data  <= 32'd0;
      wb_regwrite <= 1'b0;
    end else begin
      wb_rd_addr  <= mem_rd_addr;
      wb_rd_data  <= wb_sel;
      wb_regwrite <= mem_regwrite;
    end
  end

endmodule
